// File: rtl/seg7_pkg.sv
// Shared glyph table and helpers for the multiplexed 7-segment display driver.
// Glyphs are stored active-low in gfedcba order; the top applies board polarity.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0011000;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b0000011;
  localparam logic [6:0] GLYPH_C = 7'b1000110;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_F = 7'b0001110;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0:    seg = GLYPH_0;
      4'h1:    seg = GLYPH_1;
      4'h2:    seg = GLYPH_2;
      4'h3:    seg = GLYPH_3;
      4'h4:    seg = GLYPH_4;
      4'h5:    seg = GLYPH_5;
      4'h6:    seg = GLYPH_6;
      4'h7:    seg = GLYPH_7;
      4'h8:    seg = GLYPH_8;
      4'h9:    seg = GLYPH_9;
      4'hA:    seg = GLYPH_A;
      4'hB:    seg = GLYPH_B;
      4'hC:    seg = GLYPH_C;
      4'hD:    seg = GLYPH_D;
      4'hE:    seg = GLYPH_E;
      default: seg = GLYPH_F;
    endcase
    return seg;
  endfunction

  // Ceiling log2, used to size counters from elaboration-time parameters.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/seg7_hex_glyph.sv
// Combinational nibble-to-glyph decoder producing the active-low segment pattern.
module seg7_hex_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  assign glyph = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment bank driver with double-buffered load, frame-aligned
// update, leading-zero blanking, per-digit blink, decimal points and polarity control.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int BLINK_LOG2     = 24,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    iCLK,
  input  logic                    iRST_N,
  input  logic                    iEN,
  input  logic                    iLOAD,
  input  logic [4*NUM_DIGITS-1:0] iVALUE,
  input  logic [NUM_DIGITS-1:0]   iDP,
  input  logic                    iBLANK_LZ,
  input  logic [NUM_DIGITS-1:0]   iBLINK_MASK,
  output logic [6:0]              oSEG,
  output logic                    oDP,
  output logic [NUM_DIGITS-1:0]   oAN,
  output logic                    oPENDING,
  output logic                    oFRAME
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = clog2(SCAN_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(SCAN_DIV - 1);
  localparam logic [6:0] SEG_IDLE = SEG_ACTIVE_LOW ? SEG_OFF : ~SEG_OFF;
  localparam logic DP_IDLE = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_IDLE = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [PRE_W-1:0]        prescaler;
  logic [IDX_W-1:0]        digitIdx;
  logic [BLINK_LOG2-1:0]   blinkCnt;
  logic [4*NUM_DIGITS-1:0] shadowValue;
  logic [4*NUM_DIGITS-1:0] displayValue;
  logic [NUM_DIGITS-1:0]   shadowDp;
  logic [NUM_DIGITS-1:0]   displayDp;
  logic                    pending;
  logic                    tick;
  logic                    frameBoundary;

  logic [3:0]              curNibble;
  logic                    curDp;
  logic                    curBlank;
  logic                    curBlinkSel;
  logic [NUM_DIGITS-1:0]   lzBlank;
  logic                    upperZero;
  logic [6:0]              glyph;
  logic                    dark;
  logic [NUM_DIGITS-1:0]   anOn;
  logic [6:0]              segOn;
  logic                    dpOn;

  assign tick          = (prescaler == LAST_PRE);
  assign frameBoundary = tick && (digitIdx == LAST_IDX);
  assign oPENDING      = pending;

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      prescaler <= '0;
      digitIdx  <= '0;
      blinkCnt  <= '0;
      oFRAME    <= 1'b0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) begin
        digitIdx <= frameBoundary ? '0 : digitIdx + 1'b1;
      end
      blinkCnt <= blinkCnt + 1'b1;
      oFRAME   <= frameBoundary;
    end
  end

  // A load landing on the boundary itself bypasses the shadow so it is never left pending.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      shadowValue  <= '0;
      shadowDp     <= '0;
      displayValue <= '0;
      displayDp    <= '0;
      pending      <= 1'b0;
    end else if (frameBoundary) begin
      if (iLOAD) begin
        displayValue <= iVALUE;
        displayDp    <= iDP;
      end else if (pending) begin
        displayValue <= shadowValue;
        displayDp    <= shadowDp;
      end
      pending <= 1'b0;
    end else if (iLOAD) begin
      shadowValue <= iVALUE;
      shadowDp    <= iDP;
      pending     <= 1'b1;
    end
  end

  // A digit is a leading zero when it and every more-significant nibble are zero.
  always_comb begin
    lzBlank   = '0;
    upperZero = iBLANK_LZ;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      upperZero  = upperZero && (displayValue[4*k +: 4] == 4'h0);
      lzBlank[k] = upperZero;
    end
  end

  always_comb begin
    curNibble   = 4'h0;
    curDp       = 1'b0;
    curBlank    = 1'b0;
    curBlinkSel = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digitIdx == IDX_W'(k)) begin
        curNibble   = displayValue[4*k +: 4];
        curDp       = displayDp[k];
        curBlank    = lzBlank[k];
        curBlinkSel = iBLINK_MASK[k];
      end
    end
  end

  seg7_hex_glyph uGlyph (
    .nibble (curNibble),
    .glyph  (glyph)
  );

  // Built active-high here; a blinking digit keeps its anode so the scan duty stays even.
  always_comb begin
    anOn  = '0;
    segOn = '0;
    dpOn  = 1'b0;
    dark  = blinkCnt[BLINK_LOG2-1] && curBlinkSel;
    if (iEN) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        anOn[k] = (digitIdx == IDX_W'(k));
      end
      if (!dark) begin
        segOn = curBlank ? 7'b0000000 : ~glyph;
        dpOn  = curDp;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      oAN  <= AN_IDLE;
      oSEG <= SEG_IDLE;
      oDP  <= DP_IDLE;
    end else begin
      oAN  <= AN_ACTIVE_LOW ? ~anOn : anOn;
      oSEG <= SEG_ACTIVE_LOW ? ~segOn : segOn;
      oDP  <= SEG_ACTIVE_LOW ? ~dpOn : dpOn;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a cycle-count model predicts every output each cycle,
// and directed loads with literal expectations pin the model to known glyphs.
module tb_seg7_scan_driver;

  localparam int NUM_DIGITS = 4;
  localparam int SCAN_DIV   = 4;
  localparam int BLINK_LOG2 = 4;
  localparam int FRAME_LEN  = NUM_DIGITS * SCAN_DIV;

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic        iEN;
  logic        iLOAD;
  logic [15:0] iVALUE;
  logic [3:0]  iDP;
  logic        iBLANK_LZ;
  logic [3:0]  iBLINK_MASK;
  logic [6:0]  oSEG;
  logic        oDP;
  logic [3:0]  oAN;
  logic        oPENDING;
  logic        oFRAME;

  int errors = 0;
  int checks = 0;

  int          edgeNum;
  bit          modelValid;
  logic [3:0]  expAn;
  logic [6:0]  expSeg;
  logic        expDp;
  logic        expPend;
  logic        expFrame;
  logic [15:0] visVal;
  logic [15:0] pendVal;
  logic [3:0]  visDp;
  logic [3:0]  pendDp;
  logic        pend;
  int          mCyc;
  int          mIdx;
  bit          mDark;
  bit          mBlank;
  bit          mBoundary;

  seg7_scan_driver #(
    .NUM_DIGITS     (NUM_DIGITS),
    .SCAN_DIV       (SCAN_DIV),
    .BLINK_LOG2     (BLINK_LOG2),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .iCLK        (iCLK),
    .iRST_N      (iRST_N),
    .iEN         (iEN),
    .iLOAD       (iLOAD),
    .iVALUE      (iVALUE),
    .iDP         (iDP),
    .iBLANK_LZ   (iBLANK_LZ),
    .iBLINK_MASK (iBLINK_MASK),
    .oSEG        (oSEG),
    .oDP         (oDP),
    .oAN         (oAN),
    .oPENDING    (oPENDING),
    .oFRAME      (oFRAME)
  );

  always #5 iCLK = ~iCLK;

  function automatic logic [6:0] glyphOf(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0011000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at t=%0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  // Everything follows from the number of edges since reset: slot, blink phase and frame position.
  initial begin
    modelValid = 0;
    edgeNum    = 0;
    forever begin
      @(posedge iCLK);
      if (!iRST_N) begin
        edgeNum  = 0;
        visVal   = '0;
        visDp    = '0;
        pendVal  = '0;
        pendDp   = '0;
        pend     = 1'b0;
        expAn    = 4'b1111;
        expSeg   = 7'b1111111;
        expDp    = 1'b1;
        expPend  = 1'b0;
        expFrame = 1'b0;
        modelValid = 1;
      end else begin
        mCyc      = edgeNum;
        edgeNum   = edgeNum + 1;
        mIdx      = (mCyc / SCAN_DIV) % NUM_DIGITS;
        mDark     = ((mCyc % (1 << BLINK_LOG2)) >= (1 << (BLINK_LOG2 - 1))) && iBLINK_MASK[mIdx];
        mBoundary = (mCyc % FRAME_LEN) == FRAME_LEN - 1;
        mBlank    = iBLANK_LZ && (mIdx > 0) && ((visVal >> (4 * mIdx)) == 16'h0000);
        if (!iEN) begin
          expAn  = 4'b1111;
          expSeg = 7'b1111111;
          expDp  = 1'b1;
        end else begin
          expAn  = ~(4'b0001 << mIdx);
          expSeg = (mDark || mBlank) ? 7'b1111111 : glyphOf(visVal[4*mIdx +: 4]);
          expDp  = mDark ? 1'b1 : ~visDp[mIdx];
        end
        if (mBoundary) begin
          if (iLOAD) begin
            visVal = iVALUE;
            visDp  = iDP;
          end else if (pend) begin
            visVal = pendVal;
            visDp  = pendDp;
          end
          pend = 1'b0;
        end else if (iLOAD) begin
          pendVal = iVALUE;
          pendDp  = iDP;
          pend    = 1'b1;
        end
        expPend  = pend;
        expFrame = mBoundary;
      end
    end
  end

  initial begin
    forever begin
      @(negedge iCLK);
      if (modelValid) begin
        checkOutput("modelAN", {12'h0, oAN}, {12'h0, expAn});
        checkOutput("modelSEG", {9'h0, oSEG}, {9'h0, expSeg});
        checkOutput("modelDP", {15'h0, oDP}, {15'h0, expDp});
        checkOutput("modelPENDING", {15'h0, oPENDING}, {15'h0, expPend});
        checkOutput("modelFRAME", {15'h0, oFRAME}, {15'h0, expFrame});
      end
    end
  end

  task automatic tick();
    @(posedge iCLK);
    @(negedge iCLK);
  endtask

  task automatic goToEdge(input int k);
    for (int g = 0; g < 500 && edgeNum < k; g++) tick();
    if (edgeNum != k) begin
      checks++;
      errors++;
      $display("[TB] FAIL goToEdge: reached %0d, wanted %0d", edgeNum, k);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] value, input logic [3:0] dp);
    iVALUE = value;
    iDP    = dp;
    iLOAD  = 1'b1;
    tick();
    iLOAD  = 1'b0;
  endtask

  initial begin
    iRST_N = 1'b0; iEN = 1'b1; iLOAD = 1'b0; iVALUE = '0; iDP = '0;
    iBLANK_LZ = 1'b0; iBLINK_MASK = '0;
    @(negedge iCLK);
    repeat (3) tick();
    checkOutput("resetAN", {12'h0, oAN}, 16'h000F);
    iRST_N = 1'b1;

    goToEdge(1);
    checkOutput("firstAN", {12'h0, oAN}, 16'h000E);
    checkOutput("firstSEG", {9'h0, oSEG}, 16'h0040);
    checkOutput("firstPENDING", {15'h0, oPENDING}, 16'h0000);
    goToEdge(5);  checkOutput("scanAN1", {12'h0, oAN}, 16'h000D);
    goToEdge(9);  checkOutput("scanAN2", {12'h0, oAN}, 16'h000B);
    goToEdge(13); checkOutput("scanAN3", {12'h0, oAN}, 16'h0007);
    goToEdge(16); checkOutput("frameTick", {15'h0, oFRAME}, 16'h0001);

    goToEdge(20);
    applyStimulus(16'h12AF, 4'b0000);
    checkOutput("loadPending", {15'h0, oPENDING}, 16'h0001);
    goToEdge(32); checkOutput("transferClears", {15'h0, oPENDING}, 16'h0000);
    goToEdge(33); checkOutput("digitF", {9'h0, oSEG}, 16'h000E);
    goToEdge(37); checkOutput("digitA", {9'h0, oSEG}, 16'h0008);
    goToEdge(41); checkOutput("digit2", {9'h0, oSEG}, 16'h0024);
    goToEdge(45); checkOutput("digit1", {9'h0, oSEG}, 16'h0079);

    goToEdge(50); applyStimulus(16'h1111, 4'b0000);
    goToEdge(55); applyStimulus(16'h2222, 4'b0000);
    goToEdge(65); checkOutput("lastLoadWins", {9'h0, oSEG}, 16'h0024);

    goToEdge(79); applyStimulus(16'h3333, 4'b0000);
    checkOutput("boundaryLoadNoPend", {15'h0, oPENDING}, 16'h0000);
    goToEdge(81); checkOutput("boundaryLoadShown", {9'h0, oSEG}, 16'h0030);

    goToEdge(85);
    iBLANK_LZ = 1'b1;
    applyStimulus(16'h0050, 4'b0000);
    goToEdge(97);  checkOutput("lzDigit0", {9'h0, oSEG}, 16'h0040);
    goToEdge(101); checkOutput("lzDigit1", {9'h0, oSEG}, 16'h0012);
    goToEdge(105); checkOutput("lzDigit2", {9'h0, oSEG}, 16'h007F);
    goToEdge(109); checkOutput("lzDigit3", {9'h0, oSEG}, 16'h007F);
    goToEdge(110); applyStimulus(16'h0000, 4'b0000);
    goToEdge(113); checkOutput("zeroDigit0", {9'h0, oSEG}, 16'h0040);
    goToEdge(117); checkOutput("zeroDigit1", {9'h0, oSEG}, 16'h007F);

    goToEdge(120);
    iBLANK_LZ   = 1'b0;
    iBLINK_MASK = 4'b0101;
    applyStimulus(16'h0000, 4'b0101);
    goToEdge(129);
    checkOutput("blinkLitSEG", {9'h0, oSEG}, 16'h0040);
    checkOutput("blinkLitDP", {15'h0, oDP}, 16'h0000);
    goToEdge(133); checkOutput("noDpDigit1", {15'h0, oDP}, 16'h0001);
    goToEdge(137);
    checkOutput("blinkDarkAN", {12'h0, oAN}, 16'h000B);
    checkOutput("blinkDarkSEG", {9'h0, oSEG}, 16'h007F);
    checkOutput("blinkDarkDP", {15'h0, oDP}, 16'h0001);

    goToEdge(140);
    iEN = 1'b0;
    tick();
    checkOutput("disabledAN", {12'h0, oAN}, 16'h000F);
    checkOutput("disabledSEG", {9'h0, oSEG}, 16'h007F);
    goToEdge(143);
    iEN = 1'b1;
    tick();
    checkOutput("reenabledAN", {12'h0, oAN}, 16'h0007);

    goToEdge(150);
    applyStimulus(16'h9999, 4'b0000);
    checkOutput("prePendingReset", {15'h0, oPENDING}, 16'h0001);
    iRST_N = 1'b0;
    tick();
    checkOutput("resetDropsPending", {15'h0, oPENDING}, 16'h0000);
    checkOutput("resetDarkAN", {12'h0, oAN}, 16'h000F);
    tick();
    iRST_N = 1'b1;
    goToEdge(1);
    checkOutput("afterResetSEG", {9'h0, oSEG}, 16'h0040);
    goToEdge(17);
    checkOutput("shadowDiscarded", {9'h0, oSEG}, 16'h0040);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
